// File: rtl/serial_compare_pkg.sv
// Shared definitions for the serial wide-operand magnitude comparator:
// one-hot result codes {gt,lt,eq}, controller state encoding, nibble width.
package serial_compare_pkg;

    localparam int NIB_W = 4;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } cmp_state_t;

    // True when a compare code has decided the magnitude (not equal).
    function automatic logic is_decided(input logic [2:0] code);
        return (code == CMP_GT) || (code == CMP_LT);
    endfunction

endpackage

// File: rtl/serial_compare_seq_nibble_cmp_stage.sv
// Combinational unsigned compare of two 4-bit nibbles, one-hot {gt,lt,eq}.
module nibble_cmp_stage
    import serial_compare_pkg::*;
(
    input  logic [NIB_W-1:0] a_nib,
    input  logic [NIB_W-1:0] b_nib,
    output logic [2:0]       cmp_code
);

    // Magnitude decision for the selected nibble pair.
    always_comb begin
        cmp_code = CMP_EQ;
        if (a_nib > b_nib) begin
            cmp_code = CMP_GT;
        end else if (a_nib < b_nib) begin
            cmp_code = CMP_LT;
        end else begin
            cmp_code = CMP_EQ;
        end
    end

endmodule

// File: rtl/serial_compare_seq.sv
// Sequential wide-operand magnitude comparator. Consumes one nibble per
// clock, MSB nibble first, and falls back to the latched cascade input when
// all nibbles match. Valid/ready handshakes on operand and result sides.
// Optional build macro SERIAL_COMPARE_EARLY_EXIT_EN: when defined, the scan
// stops at the first differing nibble; otherwise every nibble is visited and
// the first difference is held (constant latency).
module serial_compare_seq
    import serial_compare_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iData_a,
    input  logic [WIDTH-1:0] iData_b,
    input  logic [2:0]       iData,
    output logic [2:0]       oData,
    output logic             oValid,
    input  logic             iReady,
    output logic             oBusy
);

    localparam int NIB   = WIDTH / NIB_W;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    cmp_state_t       state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [2:0]       casc_r;
    logic [IDX_W-1:0] idx_r;
    logic [2:0]       result_r;
    logic             ready_r;
    logic             valid_r;
    logic             busy_r;

    logic [NIB_W-1:0] a_nib_s;
    logic [NIB_W-1:0] b_nib_s;
    logic [2:0]       cmp_s;
    logic [IDX_W+1:0] bit_base_s;

`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
    logic             decided_r;
    logic [2:0]       dec_res_r;
    logic [2:0]       scan_res_s;
`endif

    // Select the nibble pair addressed by the current scan index.
    always_comb begin
        bit_base_s = {idx_r, 2'b00};
        a_nib_s    = a_r[bit_base_s +: NIB_W];
        b_nib_s    = b_r[bit_base_s +: NIB_W];
    end

    nibble_cmp_stage u_nib_cmp (
        .a_nib    (a_nib_s),
        .b_nib    (b_nib_s),
        .cmp_code (cmp_s)
    );

`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
    // Final result of a full scan: earliest difference wins, cascade last.
    always_comb begin
        scan_res_s = casc_r;
        if (decided_r) begin
            scan_res_s = dec_res_r;
        end else if (is_decided(cmp_s)) begin
            scan_res_s = cmp_s;
        end else begin
            scan_res_s = casc_r;
        end
    end
`endif

    // Controller: accept operands, scan nibbles, hold result until taken.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_r   <= ST_IDLE;
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            casc_r    <= 3'b000;
            idx_r     <= {IDX_W{1'b0}};
            result_r  <= 3'b000;
            ready_r   <= 1'b1;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
            decided_r <= 1'b0;
            dec_res_r <= 3'b000;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (iValid && ready_r) begin
                        a_r       <= iData_a;
                        b_r       <= iData_b;
                        casc_r    <= iData;
                        idx_r     <= IDX_W'(NIB - 1);
                        ready_r   <= 1'b0;
                        busy_r    <= 1'b1;
`ifndef SERIAL_COMPARE_EARLY_EXIT_EN
                        decided_r <= 1'b0;
                        dec_res_r <= 3'b000;
`endif
                        state_r   <= ST_RUN;
                    end
                end
                ST_RUN: begin
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
                    if (is_decided(cmp_s)) begin
                        result_r <= cmp_s;
                        valid_r  <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= ST_DONE;
                    end else if (idx_r != {IDX_W{1'b0}}) begin
                        idx_r    <= idx_r - IDX_W'(1);
                    end else begin
                        result_r <= casc_r;
                        valid_r  <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= ST_DONE;
                    end
`else
                    if (!decided_r && is_decided(cmp_s)) begin
                        decided_r <= 1'b1;
                        dec_res_r <= cmp_s;
                    end
                    if (idx_r != {IDX_W{1'b0}}) begin
                        idx_r    <= idx_r - IDX_W'(1);
                    end else begin
                        result_r <= scan_res_s;
                        valid_r  <= 1'b1;
                        busy_r   <= 1'b0;
                        state_r  <= ST_DONE;
                    end
`endif
                end
                ST_DONE: begin
                    // Result stays put; the next accept waits one cycle.
                    if (valid_r && iReady) begin
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    ready_r  <= 1'b1;
                    valid_r  <= 1'b0;
                    busy_r   <= 1'b0;
                    result_r <= 3'b000;
                end
            endcase
        end
    end

    assign oReady = ready_r;
    assign oValid = valid_r;
    assign oBusy  = busy_r;
    assign oData  = result_r;

endmodule

// File: tb/tb_serial_compare_seq.sv
// Randomised and directed bench for serial_compare_seq (WIDTH=16) against a
// plain-arithmetic reference: result from unsigned magnitude, latency from
// the position of the first differing nibble. Honours
// SERIAL_COMPARE_EARLY_EXIT_EN for the latency expectation.
module tb_serial_compare_seq;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] data_a;
    logic [W-1:0] data_b;
    logic [2:0]   casc;
    logic [2:0]   res;
    logic         out_valid;
    logic         cons_ready;
    logic         busy;

    int n_cmp = 0;
    int n_err = 0;

    serial_compare_seq #(.WIDTH(W)) dut (
        .iClk    (clk),
        .iRst_n  (rst_n),
        .iValid  (in_valid),
        .oReady  (out_ready),
        .iData_a (data_a),
        .iData_b (data_b),
        .iData   (casc),
        .oData   (res),
        .oValid  (out_valid),
        .iReady  (cons_ready),
        .oBusy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference result: unsigned magnitude, cascade code when equal.
    function automatic logic [2:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic [2:0] c);
        if (a > b) return 3'b100;
        if (a < b) return 3'b010;
        return c;
    endfunction

    // Reference: edges after the accept edge until oValid is seen high.
    function automatic int ref_cycles(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
        for (int k = 0; k < NIB; k++) begin
            int sh = 4 * (NIB - 1 - k);
            if (((a >> sh) & 16'hF) != ((b >> sh) & 16'hF)) return k + 1;
        end
        return NIB;
`else
        if (a == b) return NIB;
        return NIB;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, scan, optional backpressure, handshake.
    task automatic run_compare(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] c, input int hold);
        logic [2:0] exp_res;
        int         exp_cyc;
        int         cyc;
        int         guard;
        exp_res = ref_result(a, b, c);
        exp_cyc = ref_cycles(a, b);
        guard = 0;
        while (!out_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) begin
            check("wait_ready_timeout", 32'd0, 32'd1);
            return;
        end
        cons_ready = (hold == 0);
        in_valid = 1'b1;
        data_a = a;
        data_b = b;
        casc = c;
        tick();
        in_valid = 1'b0;
        data_a = $urandom;
        data_b = $urandom;
        casc = 3'($urandom);
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        check("ready_low_in_run", {31'd0, out_ready}, 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            tick();
            cyc++;
        end
        if (cyc >= 50) begin
            check("result_timeout", 32'd0, 32'd1);
            return;
        end
        check("latency", cyc, exp_cyc);
        check("result", {29'd0, res}, {29'd0, exp_res});
        check("busy_in_done", {31'd0, busy}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            data_a = $urandom;
            data_b = $urandom;
            tick();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_data", {29'd0, res}, {29'd0, exp_res});
            check("hold_ready", {31'd0, out_ready}, 32'd0);
        end
        in_valid = 1'b0;
        cons_ready = 1'b1;
        tick();
        check("post_hs_valid", {31'd0, out_valid}, 32'd0);
        check("post_hs_ready", {31'd0, out_ready}, 32'd1);
        check("post_hs_data_held", {29'd0, res}, {29'd0, exp_res});
    endtask

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int           guard;
        rst_n = 1'b0;
        in_valid = 1'b0;
        data_a = '0;
        data_b = '0;
        casc = 3'b001;
        cons_ready = 1'b1;
        #17;
        check("rst_ready", {31'd0, out_ready}, 32'd1);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_data", {29'd0, res}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed cases.
        run_compare(16'h8000, 16'h7FFF, 3'b001, 0);
        run_compare(16'h0A0A, 16'h0A0B, 3'b001, 0);
        run_compare(16'hAAAA, 16'hAAAA, 3'b001, 0);
        run_compare(16'hAAAA, 16'hAAAA, 3'b100, 0);
        run_compare(16'hAAAA, 16'hAAAA, 3'b010, 0);
        run_compare(16'h1234, 16'h1234, 3'b111, 0);
        run_compare(16'h00F0, 16'h0F00, 3'b001, 5);

        // Reset two cycles into RUN; pending result is dropped.
        in_valid = 1'b1;
        data_a = 16'h1234;
        data_b = 16'h1235;
        casc = 3'b001;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrun_rst_ready", {31'd0, out_ready}, 32'd1);
        check("midrun_rst_valid", {31'd0, out_valid}, 32'd0);
        check("midrun_rst_busy", {31'd0, busy}, 32'd0);
        check("midrun_rst_data", {29'd0, res}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        guard = 0;
        while (guard < 3) begin
            check("no_stale_result", {31'd0, out_valid}, 32'd0);
            tick();
            guard++;
        end
        run_compare(16'h0001, 16'h0000, 3'b001, 0);

        // Back-to-back with the consumer always ready.
        run_compare(16'h0100, 16'h00FF, 3'b001, 0);
        run_compare(16'h0003, 16'h0004, 3'b001, 0);
        run_compare(16'h5555, 16'h5555, 3'b001, 0);

        // Random operands, some differing in a single chosen nibble.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                rb = ra;
            end else if ($urandom_range(0, 1) == 0) begin
                rb = ra ^ (16'($urandom_range(1, 15)) << (4 * $urandom_range(0, NIB - 1)));
            end else begin
                rb = 16'($urandom);
            end
            run_compare(ra, rb, 3'($urandom), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
